// File: rtl/rv32v_vdecode_sequencer.sv
// Vector decode sequencer: splits one vector instruction into
// LANES-wide element groups and holds scalar decode while issuing.
module rv32v_vdecode_sequencer #(
    parameter int LANES = 4,
    parameter int VL_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             v_start,
    input  logic [VL_W-1:0]  vl,
    input  logic             stall_dec,
    input  logic             flush_dec,
    input  logic             exception_v,
    output logic             start_ready,
    output logic             issue_valid,
    output logic [VL_W-1:0]  elem_idx,
    output logic [LANES-1:0] elem_mask,
    output logic             issue_last,
    output logic             v_busy,
    output logic             v_decode_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [VL_W:0] LANES_X = (VL_W+1)'(LANES);

    state_t          state_q, state_d;
    logic [VL_W-1:0] idx_q, idx_d;
    logic [VL_W-1:0] vl_q, vl_d;

    logic [VL_W:0]    idx_x;
    logic [VL_W:0]    vl_x;
    logic             last_w;
    logic [LANES-1:0] mask_w;
    logic             kill_w;

    // One extra bit keeps index+LANES from wrapping near the top of VL_W.
    assign idx_x  = {1'b0, idx_q};
    assign vl_x   = {1'b0, vl_q};
    assign last_w = (idx_x + LANES_X) >= vl_x;
    assign kill_w = flush_dec | exception_v;

    // Per-lane liveness of the current group.
    always_comb begin
        mask_w = '0;
        for (int i = 0; i < LANES; i++) begin
            mask_w[i] = (idx_x + (VL_W+1)'(i)) < vl_x;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        vl_d          = vl_q;
        start_ready   = 1'b0;
        issue_valid   = 1'b0;
        elem_idx      = '0;
        elem_mask     = '0;
        issue_last    = 1'b0;
        v_busy        = 1'b0;
        v_decode_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (v_start && !kill_w) begin
                    if (vl != '0) begin
                        vl_d    = vl;
                        idx_d   = '0;
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ISSUE: begin
                issue_valid = 1'b1;
                v_busy      = 1'b1;
                elem_idx    = idx_q;
                elem_mask   = mask_w;
                issue_last  = last_w;
                if (kill_w) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (!stall_dec) begin
                    if (last_w) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + LANES_X[VL_W-1:0];
                    end
                end
            end
            DONE: begin
                // A kill in the completion cycle cancels the done pulse.
                v_decode_done = !kill_w;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, index and latched length registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vl_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vl_q    <= vl_d;
        end
    end

endmodule
